// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer results in, common data bus broadcast out
interface cdb_arbiter_if #(
  parameter int ROB_W = 4,
  parameter int DATA_W = 32
);
  logic rdy;
  logic [ROB_W-1:0] in_alu_pos;
  logic [DATA_W-1:0] in_alu_value;
  logic [ROB_W-1:0] in_lsb_pos;
  logic [DATA_W-1:0] in_lsb_value;
  logic in_lsb_io;
  logic in_rob_xbp;
  logic out_alu_full;
  logic out_lsb_full;
  logic [ROB_W-1:0] out_cdb_pos;
  logic [DATA_W-1:0] out_cdb_value;
  logic out_cdb_io;
  logic out_cdb_src;
  logic out_overflow;
  modport master (
    output rdy, in_alu_pos, in_alu_value, in_lsb_pos, in_lsb_value, in_lsb_io, in_rob_xbp,
    input out_alu_full, out_lsb_full, out_cdb_pos, out_cdb_value, out_cdb_io, out_cdb_src, out_overflow
  );
  modport slave (
    input rdy, in_alu_pos, in_alu_value, in_lsb_pos, in_lsb_value, in_lsb_io, in_rob_xbp,
    output out_alu_full, out_lsb_full, out_cdb_pos, out_cdb_value, out_cdb_io, out_cdb_src, out_overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of the CDB between ALU and LSB with per-source skid FIFOs
module cdb_arbiter #(
  parameter int ROB_W = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [ROB_W-1:0] alu_pos_m [DEPTH];
  logic [DATA_W-1:0] alu_val_m [DEPTH];
  logic [ROB_W-1:0] lsb_pos_m [DEPTH];
  logic [DATA_W-1:0] lsb_val_m [DEPTH];
  logic lsb_io_m [DEPTH];
  logic [PW-1:0] alu_rd, alu_wr, lsb_rd, lsb_wr;
  logic [CW-1:0] alu_cnt, lsb_cnt;
  logic last_lsb;
  logic flush, alu_ne, lsb_ne, alu_in, lsb_in, alu_cand, lsb_cand, gnt_alu, gnt_lsb;
  logic alu_deq, lsb_deq, alu_enq, lsb_enq, alu_ok, lsb_ok, alu_wen, lsb_wen, drop;
  logic [ROB_W-1:0] cand_pos;
  logic [DATA_W-1:0] cand_val;
  logic cand_io;
  assign flush = bus.in_rob_xbp;
  assign alu_ne = alu_cnt != '0;
  assign lsb_ne = lsb_cnt != '0;
  assign alu_in = bus.in_alu_pos != '0;
  assign lsb_in = bus.in_lsb_pos != '0;
  assign alu_cand = alu_ne | alu_in;
  assign lsb_cand = lsb_ne | lsb_in;
  // on contention the source that did not win last time goes first
  assign gnt_lsb = !flush & lsb_cand & (!alu_cand | !last_lsb);
  assign gnt_alu = !flush & alu_cand & !gnt_lsb;
  assign alu_deq = gnt_alu & alu_ne;
  assign lsb_deq = gnt_lsb & lsb_ne;
  assign alu_enq = !flush & alu_in & !(gnt_alu & !alu_ne);
  assign lsb_enq = !flush & lsb_in & !(gnt_lsb & !lsb_ne);
  assign alu_ok = alu_cnt != FULL | alu_deq;
  assign lsb_ok = lsb_cnt != FULL | lsb_deq;
  assign alu_wen = alu_enq & alu_ok;
  assign lsb_wen = lsb_enq & lsb_ok;
  assign drop = (alu_enq & !alu_ok) | (lsb_enq & !lsb_ok);
  assign cand_pos = gnt_lsb ? (lsb_ne ? lsb_pos_m[lsb_rd] : bus.in_lsb_pos)
                            : (alu_ne ? alu_pos_m[alu_rd] : bus.in_alu_pos);
  assign cand_val = gnt_lsb ? (lsb_ne ? lsb_val_m[lsb_rd] : bus.in_lsb_value)
                            : (alu_ne ? alu_val_m[alu_rd] : bus.in_alu_value);
  assign cand_io = gnt_lsb & (lsb_ne ? lsb_io_m[lsb_rd] : bus.in_lsb_io);
  assign bus.out_alu_full = alu_cnt == FULL;
  assign bus.out_lsb_full = lsb_cnt == FULL;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alu_rd <= '0;
      alu_wr <= '0;
      alu_cnt <= '0;
      lsb_rd <= '0;
      lsb_wr <= '0;
      lsb_cnt <= '0;
      last_lsb <= 1'b1;
      bus.out_cdb_pos <= '0;
      bus.out_cdb_value <= '0;
      bus.out_cdb_io <= 1'b0;
      bus.out_cdb_src <= 1'b0;
      bus.out_overflow <= 1'b0;
    end else if (bus.rdy) begin
      alu_rd <= flush ? '0 : alu_rd + PW'(alu_deq);
      alu_wr <= flush ? '0 : alu_wr + PW'(alu_wen);
      alu_cnt <= flush ? '0 : alu_cnt + CW'(alu_wen) - CW'(alu_deq);
      lsb_rd <= flush ? '0 : lsb_rd + PW'(lsb_deq);
      lsb_wr <= flush ? '0 : lsb_wr + PW'(lsb_wen);
      lsb_cnt <= flush ? '0 : lsb_cnt + CW'(lsb_wen) - CW'(lsb_deq);
      if (gnt_alu | gnt_lsb) last_lsb <= gnt_lsb;
      bus.out_cdb_pos <= (gnt_alu | gnt_lsb) ? cand_pos : '0;
      bus.out_cdb_value <= cand_val;
      bus.out_cdb_io <= cand_io;
      bus.out_cdb_src <= gnt_lsb;
      if (drop) bus.out_overflow <= 1'b1;
    end
  always_ff @(posedge clk)
    if (bus.rdy) begin
      if (alu_wen) begin
        alu_pos_m[alu_wr] <= bus.in_alu_pos;
        alu_val_m[alu_wr] <= bus.in_alu_value;
      end
      if (lsb_wen) begin
        lsb_pos_m[lsb_wr] <= bus.in_lsb_pos;
        lsb_val_m[lsb_wr] <= bus.in_lsb_value;
        lsb_io_m[lsb_wr] <= bus.in_lsb_io;
      end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with an expected-broadcast queue drained by a monitor
module tb_cdb_arbiter;
  typedef struct packed {
    logic [3:0] pos;
    logic [31:0] val;
    logic io;
    logic src;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_q = 1'b0;
  int errors = 0;
  int checks = 0;
  ent_t exq[$];
  cdb_arbiter_if #(.ROB_W(4), .DATA_W(32)) bus ();
  cdb_arbiter #(.ROB_W(4), .DATA_W(32), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) en_q <= bus.rdy && !rst;
  always @(negedge clk)
    if (en_q && !rst && bus.out_cdb_pos != '0) begin
      checks++;
      if (exq.size() == 0) begin
        errors++;
        $display("FAIL bcast: unexpected pos=%0d value=%h", bus.out_cdb_pos, bus.out_cdb_value);
      end else begin
        ent_t e;
        e = exq.pop_front();
        if ({bus.out_cdb_pos, bus.out_cdb_value, bus.out_cdb_io, bus.out_cdb_src} !== e) begin
          errors++;
          $display("FAIL bcast: got pos=%0d val=%h io=%b src=%b want pos=%0d val=%h io=%b src=%b",
                   bus.out_cdb_pos, bus.out_cdb_value, bus.out_cdb_io, bus.out_cdb_src,
                   e.pos, e.val, e.io, e.src);
        end
      end
    end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] ap, input logic [31:0] av, input logic [3:0] lp,
                       input logic [31:0] lv, input logic lio);
    bus.in_alu_pos = ap;
    bus.in_alu_value = av;
    bus.in_lsb_pos = lp;
    bus.in_lsb_value = lv;
    bus.in_lsb_io = lio;
  endtask
  task automatic push(input logic [3:0] p, input logic [31:0] v, input logic io, input logic src);
    exq.push_back('{pos: p, val: v, io: io, src: src});
  endtask
  task automatic drain(input string name);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && exq.size() != 0; i++) tick();
    tick();
    chk(name, 64'(exq.size()), 0);
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    bus.rdy = 1'b1;
    bus.in_rob_xbp = 1'b0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask
  initial begin
    int ai, li;
    logic [3:0] ap, lp;
    bus.rdy = 1'b1;
    bus.in_rob_xbp = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    chk("rst_pos", 64'(bus.out_cdb_pos), 0);
    chk("rst_value", 64'(bus.out_cdb_value), 0);
    chk("rst_io_src", {bus.out_cdb_io, bus.out_cdb_src}, 0);
    chk("rst_overflow", 64'(bus.out_overflow), 0);
    chk("rst_full", {bus.out_alu_full, bus.out_lsb_full}, 0);
    // single ALU result
    drive(3, 32'h11, 0, 0, 0);
    push(3, 32'h11, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("single_pos", 64'(bus.out_cdb_pos), 3);
    tick();
    chk("single_idle", 64'(bus.out_cdb_pos), 0);
    drain("single_drain");
    // contention after reset: ALU first
    do_reset();
    drive(5, 32'hA, 6, 32'hB, 1);
    push(5, 32'hA, 0, 0);
    push(6, 32'hB, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("cont_lsb_cnt1", 64'(dut.lsb_cnt), 1);
    tick();
    chk("cont_lsb_cnt0", 64'(dut.lsb_cnt), 0);
    drain("cont_drain");
    // sustained contention, producers stall on full
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push(4'(1 + i), 32'h100 + 32'(1 + i), 0, 0);
      push(4'(9 + i), 32'h200 + 32'(9 + i), 0, 1);
    end
    ai = 0;
    li = 0;
    for (int c = 0; c < 20 && (ai < 6 || li < 6); c++) begin
      ap = (ai < 6 && !bus.out_alu_full) ? 4'(1 + ai) : 4'd0;
      lp = (li < 6 && !bus.out_lsb_full) ? 4'(9 + li) : 4'd0;
      drive(ap, 32'h100 + 32'(ap), lp, 32'h200 + 32'(lp), 0);
      if (ap != 0) ai++;
      if (lp != 0) li++;
      tick();
      if (c == 2) chk("sus_lsb_full", 64'(bus.out_lsb_full), 1);
    end
    drain("sus_drain");
    chk("sus_overflow", 64'(bus.out_overflow), 0);
    // overflow: ALU every cycle ignoring full, LSB every other cycle
    do_reset();
    push(1, 32'h101, 0, 0);
    push(9, 32'h209, 0, 1);
    push(2, 32'h102, 0, 0);
    push(10, 32'h20A, 0, 1);
    push(3, 32'h103, 0, 0);
    push(11, 32'h20B, 0, 1);
    push(4, 32'h104, 0, 0);
    push(5, 32'h105, 0, 0);
    for (int c = 0; c < 6; c++) begin
      lp = (c % 2 == 0) ? 4'(9 + c / 2) : 4'd0;
      drive(4'(1 + c), 32'h101 + 32'(c), lp, 32'h200 + 32'(lp), 0);
      tick();
      if (c == 3) chk("ovf_alu_full", 64'(bus.out_alu_full), 1);
      if (c == 4) chk("ovf_not_yet", 64'(bus.out_overflow), 0);
      if (c == 5) chk("ovf_set", 64'(bus.out_overflow), 1);
    end
    drain("ovf_drain");
    chk("ovf_sticky", 64'(bus.out_overflow), 1);
    do_reset();
    chk("ovf_cleared", 64'(bus.out_overflow), 0);
    // flush with both FIFOs full
    push(1, 32'h101, 0, 0);
    push(9, 32'h209, 0, 1);
    push(2, 32'h102, 0, 0);
    push(10, 32'h20A, 0, 1);
    push(3, 32'h103, 0, 0);
    drive(1, 32'h101, 9, 32'h209, 0);
    tick();
    drive(2, 32'h102, 10, 32'h20A, 0);
    tick();
    drive(3, 32'h103, 11, 32'h20B, 0);
    tick();
    drive(4, 32'h104, 0, 0, 0);
    tick();
    drive(5, 32'h105, 12, 32'h20C, 0);
    tick();
    chk("fl_both_full", {bus.out_alu_full, bus.out_lsb_full}, 2'b11);
    drive(6, 32'h106, 13, 32'h20D, 0);
    bus.in_rob_xbp = 1'b1;
    tick();
    bus.in_rob_xbp = 1'b0;
    drive(7, 32'h107, 0, 0, 0);
    push(7, 32'h107, 0, 0);
    chk("fl_pos", 64'(bus.out_cdb_pos), 0);
    chk("fl_cnts", {dut.alu_cnt, dut.lsb_cnt}, 0);
    chk("fl_full", {bus.out_alu_full, bus.out_lsb_full}, 0);
    tick();
    chk("fl_new_pos", 64'(bus.out_cdb_pos), 7);
    drain("fl_drain");
    chk("fl_overflow", 64'(bus.out_overflow), 0);
    // rdy low freezes everything
    do_reset();
    drive(1, 32'h101, 9, 32'h209, 0);
    push(1, 32'h101, 0, 0);
    push(9, 32'h209, 0, 1);
    tick();
    bus.rdy = 1'b0;
    drive(2, 32'h102, 10, 32'h20A, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_hold_pos", 64'(bus.out_cdb_pos), 1);
      chk("rdy_hold_cnt", 64'(dut.lsb_cnt), 1);
    end
    bus.rdy = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    chk("rdy_resume", 64'(bus.out_cdb_pos), 9);
    drain("rdy_drain");
    // asynchronous reset mid-cycle
    drive(0, 0, 5, 32'h55, 1);
    push(5, 32'h55, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("ar_pre", {bus.out_cdb_pos, bus.out_cdb_io, bus.out_cdb_src}, {4'd5, 2'b11});
    #2;
    exq.delete();
    rst = 1'b1;
    #1;
    chk("ar_pos", 64'(bus.out_cdb_pos), 0);
    chk("ar_value", 64'(bus.out_cdb_value), 0);
    chk("ar_io_src", {bus.out_cdb_io, bus.out_cdb_src}, 0);
    rst = 1'b0;
    drain("final_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
